// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: accepts a cipher key, launches the expander,
// captures its 11 round keys into a local store and serves indexed round-key reads.
module aes_key_sched_ctrl #(
  parameter int CAP_DELAY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        key_valid_in,
  output logic        key_ready_out,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  input  logic        abort_in,
  output logic        exp_start_out,
  output logic [31:0] exp_key0_out,
  output logic [31:0] exp_key1_out,
  output logic [31:0] exp_key2_out,
  output logic [31:0] exp_key3_out,
  input  logic [31:0] exp_rk0_in,
  input  logic [31:0] exp_rk1_in,
  input  logic [31:0] exp_rk2_in,
  input  logic [31:0] exp_rk3_in,
  input  logic        rk_req_in,
  input  logic [3:0]  rk_idx_in,
  output logic        rk_valid_out,
  output logic        rk_err_out,
  output logic [31:0] rk0_out,
  output logic [31:0] rk1_out,
  output logic [31:0] rk2_out,
  output logic [31:0] rk3_out,
  output logic        keys_ready_out,
  output logic        busy_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_READY   = 3'd4
  } state_e;

  localparam int         NUM_RK   = 11;
  localparam logic [3:0] RK_LAST  = 4'd10;
  // Only reached when CAP_DELAY > 1; WAIT spans CAP_DELAY-1 cycles.
  localparam logic [1:0] DLY_LAST = 2'(CAP_DELAY - 2);

  state_e       state_q, state_d;
  logic [1:0]   dly_q, dly_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] exp_key_q, exp_key_d;
  logic         start_q, start_d;
  logic         busy_q, busy_d;
  logic         key_ready_q, key_ready_d;
  logic         keys_ready_q, keys_ready_d;
  logic         wr_en_s;
  logic [127:0] rk_in_s;
  logic [127:0] store_q [NUM_RK];
  logic [127:0] rd_data_s;
  logic         rk_valid_q, rk_valid_d;
  logic         rk_err_q, rk_err_d;
  logic [127:0] rk_data_q, rk_data_d;

  assign rk_in_s = {exp_rk0_in, exp_rk1_in, exp_rk2_in, exp_rk3_in};

  // Control FSM next state; status outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    exp_key_d = exp_key_q;
    wr_en_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (abort_in) begin
          state_d = ST_IDLE;
        end else if (key_valid_in) begin
          exp_key_d = {key0_in, key1_in, key2_in, key3_in};
          state_d   = ST_LAUNCH;
        end else begin
          state_d = state_q;
        end
      end
      ST_LAUNCH: begin
        dly_d = 2'd0;
        cnt_d = 4'd0;
        if (abort_in) begin
          state_d = ST_IDLE;
        end else if (CAP_DELAY > 1) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_WAIT: begin
        if (abort_in) begin
          state_d = ST_IDLE;
        end else if (dly_q == DLY_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          dly_d = dly_q + 2'd1;
        end
      end
      ST_CAPTURE: begin
        if (abort_in) begin
          state_d = ST_IDLE;
        end else begin
          wr_en_s = 1'b1;
          if (cnt_q == RK_LAST) begin
            state_d = ST_READY;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    start_d      = (state_d == ST_LAUNCH);
    busy_d       = (state_d == ST_LAUNCH) || (state_d == ST_WAIT) || (state_d == ST_CAPTURE);
    key_ready_d  = (state_d == ST_IDLE) || (state_d == ST_READY);
    keys_ready_d = (state_d == ST_READY);
  end

  // Control state and registered status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      dly_q        <= 2'd0;
      cnt_q        <= 4'd0;
      exp_key_q    <= 128'd0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      key_ready_q  <= 1'b1;
      keys_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      cnt_q        <= cnt_d;
      exp_key_q    <= exp_key_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      key_ready_q  <= key_ready_d;
      keys_ready_q <= keys_ready_d;
    end
  end

  // Round-key store, written only while capturing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_RK; i++) begin
        store_q[i] <= 128'd0;
      end
    end else begin
      for (int i = 0; i < NUM_RK; i++) begin
        if (wr_en_s && (cnt_q == 4'(i))) begin
          store_q[i] <= rk_in_s;
        end
      end
    end
  end

  // Read-port response; keys_ready_q still reflects the old schedule in the accept cycle.
  always_comb begin
    rd_data_s  = 128'd0;
    rk_valid_d = rk_req_in;
    rk_err_d   = 1'b0;
    rk_data_d  = 128'd0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rk_idx_in == 4'(i)) begin
        rd_data_s = store_q[i];
      end else begin
        rd_data_s = rd_data_s;
      end
    end
    if (rk_req_in) begin
      if (keys_ready_q && (rk_idx_in <= RK_LAST)) begin
        rk_data_d = rd_data_s;
      end else begin
        rk_err_d = 1'b1;
      end
    end else begin
      rk_err_d = 1'b0;
    end
  end

  // Read-port response registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      rk_data_q  <= 128'd0;
    end else begin
      rk_valid_q <= rk_valid_d;
      rk_err_q   <= rk_err_d;
      rk_data_q  <= rk_data_d;
    end
  end

  assign key_ready_out  = key_ready_q;
  assign exp_start_out  = start_q;
  assign exp_key0_out   = exp_key_q[127:96];
  assign exp_key1_out   = exp_key_q[95:64];
  assign exp_key2_out   = exp_key_q[63:32];
  assign exp_key3_out   = exp_key_q[31:0];
  assign rk_valid_out   = rk_valid_q;
  assign rk_err_out     = rk_err_q;
  assign rk0_out        = rk_data_q[127:96];
  assign rk1_out        = rk_data_q[95:64];
  assign rk2_out        = rk_data_q[63:32];
  assign rk3_out        = rk_data_q[31:0];
  assign keys_ready_out = keys_ready_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: FIPS-197 expander model driving the DUT, timing-rule
// reference model of the controller, directed scenarios plus randomized traffic.
module tb_aes_key_sched_ctrl;

  localparam int CD  = 1;
  localparam int CD3 = 3;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic         key_valid_in, kv3, abort_in, rk_req_in;
  logic [3:0]   rk_idx_in;
  logic [127:0] key_in, exp_rk, exp_rk3;
  wire          key_ready_out, exp_start_out, rk_valid_out, rk_err_out, keys_ready_out, busy_out;
  wire  [127:0] xk1, rd1;
  wire          key_ready3, exp_start3, rk_valid3, rk_err3, keys_ready3, busy3;
  wire  [127:0] xk3, rd3;

  aes_key_sched_ctrl #(.CAP_DELAY(CD)) u_dut (
    .CLK(CLK), .RST(RST), .key_valid_in(key_valid_in), .key_ready_out(key_ready_out),
    .key0_in(key_in[127:96]), .key1_in(key_in[95:64]), .key2_in(key_in[63:32]), .key3_in(key_in[31:0]),
    .abort_in(abort_in), .exp_start_out(exp_start_out),
    .exp_key0_out(xk1[127:96]), .exp_key1_out(xk1[95:64]), .exp_key2_out(xk1[63:32]), .exp_key3_out(xk1[31:0]),
    .exp_rk0_in(exp_rk[127:96]), .exp_rk1_in(exp_rk[95:64]), .exp_rk2_in(exp_rk[63:32]), .exp_rk3_in(exp_rk[31:0]),
    .rk_req_in(rk_req_in), .rk_idx_in(rk_idx_in), .rk_valid_out(rk_valid_out), .rk_err_out(rk_err_out),
    .rk0_out(rd1[127:96]), .rk1_out(rd1[95:64]), .rk2_out(rd1[63:32]), .rk3_out(rd1[31:0]),
    .keys_ready_out(keys_ready_out), .busy_out(busy_out)
  );

  aes_key_sched_ctrl #(.CAP_DELAY(CD3)) u_dut3 (
    .CLK(CLK), .RST(RST), .key_valid_in(kv3), .key_ready_out(key_ready3),
    .key0_in(key_in[127:96]), .key1_in(key_in[95:64]), .key2_in(key_in[63:32]), .key3_in(key_in[31:0]),
    .abort_in(1'b0), .exp_start_out(exp_start3),
    .exp_key0_out(xk3[127:96]), .exp_key1_out(xk3[95:64]), .exp_key2_out(xk3[63:32]), .exp_key3_out(xk3[31:0]),
    .exp_rk0_in(exp_rk3[127:96]), .exp_rk1_in(exp_rk3[95:64]), .exp_rk2_in(exp_rk3[63:32]), .exp_rk3_in(exp_rk3[31:0]),
    .rk_req_in(rk_req_in), .rk_idx_in(rk_idx_in), .rk_valid_out(rk_valid3), .rk_err_out(rk_err3),
    .rk0_out(rd3[127:96]), .rk1_out(rd3[95:64]), .rk2_out(rd3[63:32]), .rk3_out(rd3[31:0]),
    .keys_ready_out(keys_ready3), .busy_out(busy3)
  );

  // ---------------- AES-128 key expansion (FIPS-197) ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x} >> (8 - n);
    return d[7:0];
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  // Expander models: round key k is presented CAP_DELAY+k cycles after the start cycle.
  initial begin : expander1
    int ph;
    logic [127:0] ek;
    ph = 100; ek = 128'd0; exp_rk = 128'd0;
    forever begin
      @(negedge CLK);
      if (!RST) ph = 100;
      else if (exp_start_out) begin ph = 0; ek = xk1; end
      else if (ph < 100) ph++;
      if (ph >= CD && ph <= CD + 10) exp_rk = round_key(ek, ph - CD);
      else exp_rk = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  initial begin : expander3
    int ph;
    logic [127:0] ek;
    ph = 100; ek = 128'd0; exp_rk3 = 128'd0;
    forever begin
      @(negedge CLK);
      if (!RST) ph = 100;
      else if (exp_start3) begin ph = 0; ek = xk3; end
      else if (ph < 100) ph++;
      if (ph >= CD3 && ph <= CD3 + 10) exp_rk3 = round_key(ek, ph - CD3);
      else exp_rk3 = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // ---------------- checking and reference model ----------------
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: observed %h, expected %h", tag, cyc, obs, exp);
  endtask

  bit           m_busy, m_ready, m_kready;
  int           launch_c, ready_c;
  logic [127:0] m_xkey;
  logic [127:0] m_store [11];
  bit           pend_v, pend_err;
  logic [127:0] pend_d;

  // Advance one cycle: apply the controller's timing rules to the inputs, then check every output.
  task automatic step();
    pend_v   = rk_req_in;
    pend_err = !(m_ready && rk_idx_in <= 4'd10);
    pend_d   = 128'd0;
    if (!pend_err) pend_d = m_store[rk_idx_in];
    if (abort_in && (m_busy || m_ready)) begin
      m_busy = 0; m_ready = 0; m_kready = 1;
    end else if (key_valid_in && m_kready && !abort_in) begin
      m_xkey = key_in; launch_c = cyc + 1; ready_c = cyc + 12 + CD;
      m_busy = 1; m_ready = 0; m_kready = 0;
    end
    @(negedge CLK);
    cyc++;
    if (m_busy && cyc == ready_c) begin
      m_busy = 0; m_ready = 1; m_kready = 1;
      for (int k = 0; k < 11; k++) m_store[k] = round_key(m_xkey, k);
    end
    chk("rk_valid", rk_valid_out, pend_v);
    if (pend_v) begin
      chk("rk_err", rk_err_out, pend_err);
      chk("rk_data", rd1, pend_d);
    end
    chk("key_ready", key_ready_out, m_kready);
    chk("keys_ready", keys_ready_out, m_ready);
    chk("busy", busy_out, m_busy);
    chk("exp_start", exp_start_out, m_busy && cyc == launch_c);
    chk("exp_key", xk1, m_xkey);
  endtask

  task automatic chk_rst();
    chk("rst_key_ready", key_ready_out, 1'b1);
    chk("rst_exp_start", exp_start_out, 1'b0);
    chk("rst_exp_key", xk1, 128'd0);
    chk("rst_rk_valid", rk_valid_out, 1'b0);
    chk("rst_rk_err", rk_err_out, 1'b0);
    chk("rst_rk_data", rd1, 128'd0);
    chk("rst_keys_ready", keys_ready_out, 1'b0);
    chk("rst_busy", busy_out, 1'b0);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
    rk_req_in = 1'b1; rk_idx_in = idx;
    step();
    rk_req_in = 1'b0;
    chk("rd_const_data", rd1, exp);
    chk("rd_const_err", rk_err_out, 1'b0);
  endtask

  task automatic burst_down();
    int nv = 0;
    for (int i = 10; i >= 0; i--) begin
      rk_req_in = 1'b1; rk_idx_in = 4'(i);
      step();
      if (rk_valid_out) nv++;
    end
    rk_req_in = 1'b0;
    step();
    if (rk_valid_out) nv++;
    chk("burst_valid_cnt", nv, 11);
  endtask

  task automatic accept_key(input logic [127:0] k, output int t0);
    key_in = k; key_valid_in = 1'b1; t0 = cyc;
    step();
    key_valid_in = 1'b0;
  endtask

  initial begin
    int t0, starts, first_start, fr, fr3;
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h01;
      for (int n = 0; n < 254; n++) inv = gmul(inv, 8'(a));
      sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    key_valid_in = 1'b0; kv3 = 1'b0; abort_in = 1'b0; rk_req_in = 1'b0; rk_idx_in = 4'd0; key_in = 128'd0;
    m_busy = 0; m_ready = 0; m_kready = 1; m_xkey = 128'd0; launch_c = -1; ready_c = -1;
    for (int k = 0; k < 11; k++) m_store[k] = 128'd0;
    #12;
    chk_rst();
    chk("rst_d3_key_ready", key_ready3, 1'b1);
    chk("rst_d3_busy", busy3, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    step(); step();

    // FIPS-197 key on both builds
    key_in = FIPS_KEY; key_valid_in = 1'b1; kv3 = 1'b1; t0 = cyc;
    step();
    key_valid_in = 1'b0; kv3 = 1'b0;
    starts = 0; first_start = -1; fr = -1; fr3 = -1;
    for (int j = 0; j < 20; j++) begin
      if (exp_start_out) begin starts++; if (first_start < 0) first_start = cyc - t0; end
      if (keys_ready_out && fr < 0) fr = cyc - t0;
      if (keys_ready3 && fr3 < 0) fr3 = cyc - t0;
      step();
    end
    chk("start_cycle", first_start, 1);
    chk("start_count", starts, 1);
    chk("ready_cycle", fr, 13);
    chk("ready_cycle_cd3", fr3, 15);
    rk_req_in = 1'b1; rk_idx_in = 4'd1;
    step();
    rk_req_in = 1'b0;
    chk("rk1_data", rd1, FIPS_RK1);
    chk("cd3_rk1_valid", rk_valid3, 1'b1);
    chk("cd3_rk1_err", rk_err3, 1'b0);
    chk("cd3_rk1_data", rd3, FIPS_RK1);
    rd(4'd0, FIPS_KEY);
    rd(4'd10, FIPS_RK10);
    burst_down();
    rk_req_in = 1'b1; rk_idx_in = 4'd11;
    step();
    rk_req_in = 1'b0;
    chk("idx11_err", rk_err_out, 1'b1);
    chk("idx11_data", rd1, 128'd0);

    // key held valid through capture; read during capture
    key_in = {$urandom, $urandom, $urandom, $urandom}; key_valid_in = 1'b1; t0 = cyc;
    step();
    key_in = {$urandom, $urandom, $urandom, $urandom};
    starts = 0;
    for (int j = 0; j < 30; j++) begin
      if (exp_start_out) starts++;
      rk_req_in = (cyc == t0 + 5); rk_idx_in = 4'd3;
      if (cyc == t0 + 14) key_valid_in = 1'b0;
      step();
      if (cyc == t0 + 6) begin
        chk("cap_rd_valid", rk_valid_out, 1'b1);
        chk("cap_rd_err", rk_err_out, 1'b1);
        chk("cap_rd_data", rd1, 128'd0);
      end
    end
    rk_req_in = 1'b0;
    chk("held_key_starts", starts, 2);

    // abort at capture index 5, then a clean key
    accept_key({$urandom, $urandom, $urandom, $urandom}, t0);
    while (cyc < t0 + 7) step();
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    chk("abort_busy", busy_out, 1'b0);
    chk("abort_keys_ready", keys_ready_out, 1'b0);
    chk("abort_key_ready", key_ready_out, 1'b1);
    accept_key({$urandom, $urandom, $urandom, $urandom}, t0);
    repeat (13) step();
    burst_down();

    // abort in READY wins over a key offered the same cycle
    abort_in = 1'b1; key_valid_in = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    step();
    abort_in = 1'b0; key_valid_in = 1'b0;
    chk("abort_ready_keys_ready", keys_ready_out, 1'b0);
    repeat (3) step();
    chk("abort_ready_no_launch", busy_out, 1'b0);

    // reset at capture index 7
    accept_key({$urandom, $urandom, $urandom, $urandom}, t0);
    while (cyc < t0 + 9) step();
    #2 RST = 1'b0;
    #1 chk_rst();
    m_busy = 0; m_ready = 0; m_kready = 1; m_xkey = 128'd0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    step();
    accept_key({$urandom, $urandom, $urandom, $urandom}, t0);
    repeat (13) step();
    chk("post_rst_ready", keys_ready_out, 1'b1);
    burst_down();

    // randomized traffic
    for (int j = 0; j < 400; j++) begin
      key_in       = {$urandom, $urandom, $urandom, $urandom};
      key_valid_in = ($urandom_range(0, 15) == 0);
      abort_in     = ($urandom_range(0, 79) == 0);
      rk_req_in    = 1'($urandom_range(0, 1));
      rk_idx_in    = 4'($urandom_range(0, 12));
      step();
    end
    key_valid_in = 1'b0; abort_in = 1'b0; rk_req_in = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
